// File: rtl/synth_cmd_pkg.sv
// Shared command-word definitions for the synth host write stream.
// The host driver build uses the same opcodes, field positions and state names.
package synth_cmd_pkg;
  localparam int CMD_W = 32;
  localparam int OP_HI = 31;
  localparam int OP_LO = 30;

  localparam logic [1:0] OP_NOTE    = 2'b00;
  localparam logic [1:0] OP_VEL     = 2'b01;
  localparam logic [1:0] OP_ALL_OFF = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;
endpackage

// File: rtl/note_cmd_decoder_if.sv
// Host command channel: valid/ready handshake carrying 32-bit command words.
interface note_cmd_decoder_if;
  logic                           cmd_valid;
  logic [synth_cmd_pkg::CMD_W-1:0] cmd_data;
  logic                           cmd_ready;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/gap_down_counter.sv
// Loadable down counter that stops at zero; times the gate-low retrigger gap.
module gap_down_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                   value <= '0;
    else if (load)                value <= load_val;
    else if (dec && value != '0)  value <= value - 1'b1;
  end

  assign zero = (value == '0);
endmodule

// File: rtl/note_cmd_decoder.sv
// Decodes host command words into period/velocity/gate voice controls,
// inserting a fixed gate-low gap on pitch changes so the envelope retriggers.
module note_cmd_decoder
  import synth_cmd_pkg::*;
#(
  parameter int PERIOD_W   = 23,
  parameter int VEL_W      = 7,
  parameter int RETRIG_GAP = 16,
  parameter int MIN_PERIOD = 2
) (
  input  logic                clk,
  input  logic                rst_b,
  note_cmd_decoder_if.slave   cmd,
  output logic [PERIOD_W-1:0] period,
  output logic [VEL_W-1:0]    velocity,
  output logic                gate,
  output logic                note_on,
  output logic                note_off,
  output logic [7:0]          err_cnt
);
  if (RETRIG_GAP < 1 || MIN_PERIOD < 1) begin : g_bad_param
    $error("note_cmd_decoder: RETRIG_GAP and MIN_PERIOD must both be >= 1");
  end

  localparam int                CW    = $clog2(RETRIG_GAP) + 1;
  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
  localparam logic [CW-1:0]     GAP_LD = CW'(RETRIG_GAP - 1);

  state_e              state, state_n;
  logic                rst_q;
  logic [PERIOD_W-1:0] pending, pending_n, period_n;
  logic [VEL_W-1:0]    velocity_n;
  logic                gate_n, note_on_n, note_off_n;
  logic [7:0]          err_cnt_n;
  logic                cnt_load, cnt_zero;
  logic [CW-1:0]       cnt_value;

  logic                accept;
  logic [1:0]          op;
  logic [PERIOD_W-1:0] p;
  logic                unused_data;

  assign op          = cmd.cmd_data[OP_HI:OP_LO];
  assign p           = cmd.cmd_data[PERIOD_W-1:0];
  assign unused_data = ^cmd.cmd_data;

  // Ready is held low out of reset until the first clock, and throughout the gap.
  assign cmd.cmd_ready = rst_q & (state != GAP);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;

  gap_down_counter #(.W(CW)) u_gap (
    .clk      (clk),
    .rst_b    (rst_b),
    .load     (cnt_load),
    .load_val (GAP_LD),
    .dec      (state == GAP),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rst_q    <= 1'b0;
      state    <= IDLE;
      period   <= '0;
      velocity <= '1;
      gate     <= 1'b0;
      note_on  <= 1'b0;
      note_off <= 1'b0;
      err_cnt  <= '0;
      pending  <= '0;
    end else begin
      rst_q    <= 1'b1;
      state    <= state_n;
      period   <= period_n;
      velocity <= velocity_n;
      gate     <= gate_n;
      note_on  <= note_on_n;
      note_off <= note_off_n;
      err_cnt  <= err_cnt_n;
      pending  <= pending_n;
    end
  end

  always_comb begin
    state_n    = state;
    period_n   = period;
    velocity_n = velocity;
    gate_n     = gate;
    note_on_n  = 1'b0;
    note_off_n = 1'b0;
    err_cnt_n  = err_cnt;
    pending_n  = pending;
    cnt_load   = 1'b0;

    if (state == GAP) begin
      if (cnt_zero) begin
        period_n  = pending;
        note_on_n = 1'b1;
        gate_n    = 1'b1;
        state_n   = PLAY;
      end
    end else if (accept) begin
      // Malformed words are consumed but only bump the error count.
      if (op == OP_RSVD || (op == OP_NOTE && p != '0 && p < MIN_P)) begin
        if (err_cnt != 8'hFF) err_cnt_n = err_cnt + 8'd1;
      end else if (op == OP_VEL) begin
        velocity_n = cmd.cmd_data[VEL_W-1:0];
      end else if (op == OP_ALL_OFF || p == '0) begin
        if (state == PLAY) begin
          note_off_n = 1'b1;
          gate_n     = 1'b0;
          state_n    = IDLE;
        end
      end else if (state == IDLE) begin
        period_n  = p;
        note_on_n = 1'b1;
        gate_n    = 1'b1;
        state_n   = PLAY;
      end else if (p != period) begin
        note_off_n = 1'b1;
        gate_n     = 1'b0;
        pending_n  = p;
        cnt_load   = 1'b1;
        state_n    = GAP;
      end
    end
  end
endmodule

// File: tb/tb_note_cmd_decoder.sv
// Directed and randomized checks of note_cmd_decoder against a cycle-level voice model.
module tb_note_cmd_decoder;
  localparam int PW = 23;
  localparam int VW = 7;
  localparam int RG = 16;
  localparam int MP = 2;

  logic clk = 1'b0;
  logic rst_b;
  logic [PW-1:0] period;
  logic [VW-1:0] velocity;
  logic gate, note_on, note_off;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;

  // Model: what a listener should hear, tracked as plain integers.
  int m_period, m_vel, m_err, m_gap, m_pend;
  bit m_gate, m_on, m_off, m_rstq;
  bit seen_on;

  note_cmd_decoder_if cmd_if ();

  note_cmd_decoder #(.PERIOD_W(PW), .VEL_W(VW), .RETRIG_GAP(RG), .MIN_PERIOD(MP)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .cmd      (cmd_if.slave),
    .period   (period),
    .velocity (velocity),
    .gate     (gate),
    .note_on  (note_on),
    .note_off (note_off),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_period = 0; m_vel = 127; m_err = 0; m_gap = 0; m_pend = 0;
    m_gate = 0; m_on = 0; m_off = 0; m_rstq = 0;
  endtask

  task automatic check_outputs();
    chk("period",   32'(period),   32'(m_period));
    chk("velocity", 32'(velocity), 32'(m_vel));
    chk("gate",     32'(gate),     32'(m_gate));
    chk("note_on",  32'(note_on),  32'(m_on));
    chk("note_off", 32'(note_off), 32'(m_off));
    chk("err_cnt",  32'(err_cnt),  32'(m_err));
  endtask

  // Present one word for one clock, predict the result, check after the edge.
  task automatic cycle(input logic v, input logic [31:0] d);
    bit exp_ready;
    int op, p;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_data  = d;
    exp_ready = m_rstq && (m_gap == 0);
    chk("cmd_ready", 32'(cmd_if.cmd_ready), 32'(exp_ready));
    op = int'(d[31:30]);
    p  = int'(d[PW-1:0]);
    m_on = 0; m_off = 0;
    if (rst_b) begin
      if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0) begin m_period = m_pend; m_gate = 1; m_on = 1; end
      end else if (v && exp_ready) begin
        if (op == 3 || (op == 0 && p > 0 && p < MP)) m_err = (m_err < 255) ? m_err + 1 : 255;
        else if (op == 1) m_vel = int'(d[VW-1:0]);
        else if (op == 2 || p == 0) begin
          if (m_gate) begin m_gate = 0; m_off = 1; end
        end else if (!m_gate) begin m_period = p; m_gate = 1; m_on = 1; end
        else if (p != m_period) begin m_gate = 0; m_off = 1; m_pend = p; m_gap = RG; end
      end
      m_rstq = 1;
    end
    @(posedge clk); #1;
    if (note_on) seen_on = 1;
    check_outputs();
  endtask

  function automatic logic [31:0] note(input int p);
    return {2'b00, 30'(p)};
  endfunction

  initial begin
    int gate_low;
    logic [31:0] w;
    int sel;
    model_reset();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_data  = '0;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // 1. reset values and ready held low
    check_outputs();
    chk("ready_in_reset", 32'(cmd_if.cmd_ready), 32'd0);
    rst_b = 1'b1;
    cycle(0, '0);
    chk("ready_after_release", 32'(cmd_if.cmd_ready), 32'd1);

    // 2. first note from IDLE
    cycle(1, note(32'h100));
    chk("note_period", 32'(period), 32'h100);
    chk("note_on_pulse", 32'(note_on), 32'd1);
    cycle(0, '0);
    chk("note_on_single", 32'(note_on), 32'd0);

    // 4. same pitch: no retrigger; velocity update
    cycle(1, note(32'h100));
    chk("same_pitch_off", 32'(note_off), 32'd0);
    cycle(1, 32'h4000_0040);
    chk("vel_40", 32'(velocity), 32'h40);

    // 3. pitch change: gate low for exactly RG cycles
    cycle(1, note(32'h200));
    chk("retrig_off", 32'(note_off), 32'd1);
    gate_low = 1;
    for (int i = 0; i < RG + 5 && !gate; i++) begin
      cycle(1, note(32'h300));
      if (!gate) gate_low++;
    end
    chk("gap_len", 32'(gate_low), 32'(RG));
    chk("retrig_period", 32'(period), 32'h200);
    chk("retrig_ready", 32'(cmd_if.cmd_ready), 32'd1);

    // 5. note off holds period; ALL_OFF in IDLE does nothing
    cycle(1, note(0));
    chk("off_period_hold", 32'(period), 32'h200);
    cycle(1, 32'h8000_0000);
    cycle(0, '0);

    // 6. error words and saturation
    cycle(1, 32'hC000_0000);
    chk("err_1", 32'(err_cnt), 32'd1);
    cycle(1, note(1));
    chk("err_2", 32'(err_cnt), 32'd2);
    for (int i = 0; i < 300; i++) cycle(1, (i % 2) ? 32'hC000_1234 : note(1));
    chk("err_sat", 32'(err_cnt), 32'd255);

    // Reset mid-GAP: no delayed note_on, outputs back to reset values
    cycle(1, note(32'h100));
    cycle(1, note(32'h155));
    repeat (4) cycle(0, '0);
    rst_b = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("ready_rst_gap", 32'(cmd_if.cmd_ready), 32'd0);
    seen_on = 0;
    repeat (3) cycle(1, note(32'h222));
    rst_b = 1'b1;
    repeat (RG + 4) cycle(0, '0);
    chk("no_note_on_after_rst", 32'(seen_on), 32'd0);

    // Randomized traffic with a small pitch pool so repeats and retriggers occur
    for (int i = 0; i < 1500; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3: w = note(int'($urandom_range(0, 3)) * 32'h80);
        4:          w = note(int'($urandom_range(0, 3)));
        5:          w = note(int'($urandom_range(0, 32'h7F_FFFF)));
        6:          w = {2'b01, 30'($urandom)};
        7:          w = {2'b10, 30'($urandom)};
        8:          w = {2'b11, 30'($urandom)};
        default:    w = $urandom;
      endcase
      cycle(1'($urandom_range(0, 1)), w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
